// File: rtl/dm_pkg.sv
// Shared definitions for the MEM-stage data-memory bridge.
//   size_e  : access size code, same encoding as the byte-enable control
//   state_e : bridge FSM state encoding
//   BE_ALL  : byte-enable mask used for loads (whole word read)
package dm_pkg;

  typedef enum logic [1:0] {
    SZ_NONE = 2'd0,
    SZ_WORD = 2'd1,
    SZ_HALF = 2'd2,
    SZ_BYTE = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [3:0] BE_ALL = 4'b1111;

endpackage

// File: rtl/dm_align_chk.sv
// Combinational misalignment decode for a MEM-stage request.
//   req_valid   : request present
//   req_we      : 1 = store, 0 = load
//   req_size    : size code (dm_pkg::size_e encoding)
//   req_addr_lo : low two bits of the byte address
//   mis         : request is misaligned for its size
//   exc_adel    : misaligned load
//   exc_ades    : misaligned store
module dm_align_chk
  import dm_pkg::*;
(
  input  logic       req_valid,
  input  logic       req_we,
  input  logic [1:0] req_size,
  input  logic [1:0] req_addr_lo,
  output logic       mis,
  output logic       exc_adel,
  output logic       exc_ades
);

  logic word_bad;
  logic half_bad;

  // Bytes can never be misaligned; words need both low bits clear, halves bit 0.
  assign word_bad = (req_size == SZ_WORD) && (req_addr_lo != 2'b00);
  assign half_bad = (req_size == SZ_HALF) && req_addr_lo[0];

  assign mis      = req_valid & (word_bad | half_bad);
  assign exc_adel = mis & ~req_we;
  assign exc_ades = mis & req_we;

endmodule

// File: rtl/dm_bridge.sv
// MEM-stage data-memory bridge: runs one load/store per instruction over a
// valid/ready bus with variable latency, stalling the pipeline meanwhile.
//   clk, rst_n        : clock, asynchronous active-low reset
//   req_*             : request from the MEM stage (held stable while stall=1)
//   stall             : freeze the pipeline registers
//   rdata/rdata_valid : registered load word and its one-cycle strobe
//   exc_adel/exc_ades : misaligned load/store (combinational, IDLE only)
//   bus_fault         : one-cycle pulse when a transfer times out
//   bus_*             : registered bus request; bus_ready/bus_rdata from slave
module dm_bridge
  import dm_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        bus_fault,
  output logic        bus_valid,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic mis;
  logic adel_raw;
  logic ades_raw;
  logic in_idle;
  logic go;

  dm_align_chk u_align_chk (
    .req_valid   (req_valid),
    .req_we      (req_we),
    .req_size    (req_size),
    .req_addr_lo (req_addr[1:0]),
    .mis         (mis),
    .exc_adel    (adel_raw),
    .exc_ades    (ades_raw)
  );

  assign in_idle  = (state_reg == ST_IDLE);
  assign go       = req_valid & (req_size != SZ_NONE) & ~mis;

  // Exceptions only in IDLE: in DONE the same, already-served request is still
  // on the inputs and must not be reported again.
  assign exc_adel = adel_raw & in_idle;
  assign exc_ades = ades_raw & in_idle;

  // DONE deliberately drops stall so the pipeline advances past the request.
  assign stall    = (in_idle & go) | (state_reg == ST_REQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      bus_valid   <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      bus_be      <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      bus_fault   <= 1'b0;
    end else begin
      // Both strobes are single-cycle; they are only set on the REQ->DONE step.
      rdata_valid <= 1'b0;
      bus_fault   <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (go) begin
            bus_valid <= 1'b1;
            bus_we    <= req_we;
            bus_addr  <= {req_addr[31:2], 2'b00};
            bus_wdata <= req_wdata;
            bus_be    <= req_we ? req_be : BE_ALL;
            cnt_reg   <= '0;
            state_reg <= ST_REQ;
          end
        end
        ST_REQ: begin
          // bus_ready takes priority over a timeout in the same cycle.
          if (bus_ready) begin
            bus_valid <= 1'b0;
            if (!bus_we) begin
              rdata       <= bus_rdata;
              rdata_valid <= 1'b1;
            end
            state_reg <= ST_DONE;
          end else if (cnt_reg == CNT_LAST) begin
            bus_valid <= 1'b0;
            bus_fault <= 1'b1;
            // A store never disturbs the last load word.
            if (!bus_we) begin
              rdata <= '0;
            end
            state_reg <= ST_DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/dm_bridge.md
Name: dm_bridge

Overview:
- MEM-stage data-memory bridge. Takes one load/store request per instruction from the pipeline, already carrying the byte enables from the store byte-enable generator.
- Runs the request over a simple valid/ready memory bus with variable latency, stalling the pipeline until the bus responds.
- Returns the raw 32-bit read word to the load extender.
- Detects misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT, 255, REQ-state cycles without bus_ready before the transaction is abandoned (1..255).
- CNT_W, 8, width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset: one clock; reset is asynchronous and active-low.
- req_valid  in  1  MEM stage holds a load or store; stays stable while stall=1.
- req_we  in  1  1=store, 0=load.
- req_size  in  2  1=word, 2=half, 3=byte (same encoding as the byte-enable control); 0=no access.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, already lane-aligned.
- req_be  in  4  byte enables for stores; ignored for loads.
- stall  out  1  freeze PC/IF/ID/EX/MEM pipeline registers.
- rdata  out  32  registered read word, word-aligned, to the load extender.
- rdata_valid  out  1  one-cycle pulse: rdata holds the completed load data.
- exc_adel  out  1  misaligned load (combinational).
- exc_ades  out  1  misaligned store (combinational).
- bus_fault  out  1  one-cycle pulse: transaction timed out.
- bus_valid  out  1  registered bus request.
- bus_we  out  1  registered.
- bus_addr  out  32  registered, {req_addr[31:2],2'b00}.
- bus_wdata  out  32  registered.
- bus_be  out  4  registered: req_be for stores, 4'b1111 for loads.
- bus_ready  in  1  slave accepts/completes the transfer this cycle.
- bus_rdata  in  32  valid when bus_ready=1 and bus_we=0.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, counter=0.
  - bus_valid, bus_we, bus_addr, bus_wdata, bus_be, rdata, rdata_valid and bus_fault all go to 0 immediately.
  - stall=0.
  - Reset mid-transaction abandons the transaction with no fault pulse.
- Misalignment (combinational, decoded from req_size and req_addr[1:0]):
  - mis = req_valid & ((size=1 & addr[1:0]!=0) | (size=2 & addr[0]!=0)).
  - exc_adel = mis & ~req_we; exc_ades = mis & req_we; both are gated to IDLE only.
  - A misaligned request never starts a bus transaction and keeps stall=0, so the pipeline flushes it next cycle.
- stall = (state==IDLE & go) | state==REQ, where go = req_valid & req_size!=0 & ~mis.
- IDLE:
  - If go: latch bus_* from the request, bus_valid<=1, counter<=0, go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - bus_valid, bus_we, bus_addr, bus_wdata and bus_be are held stable until bus_ready is sampled 1.
  - If bus_ready: bus_valid<=0. For a load, rdata<=bus_rdata and rdata_valid<=1. Go to DONE.
  - Else if counter==TIMEOUT-1: bus_valid<=0, rdata<=0, bus_fault<=1, go to DONE.
  - Else counter<=counter+1.
  - bus_ready and the timeout in the same cycle: bus_ready wins, no fault.
- DONE:
  - stall=0, so the pipeline advances at the end of this cycle and the load extender and write-back consume rdata.
  - rdata_valid and bus_fault clear next cycle; rdata holds its value until the next load completes.
  - Unconditionally return to IDLE. The DONE-cycle request is the same, already-completed instruction and must not restart.
- Latency: a load with bus_ready=1 on the first REQ cycle completes in 3 cycles (IDLE, REQ, DONE); each extra wait cycle adds 1.
- Back-to-back accesses: the next request is seen in IDLE on the cycle after DONE. There is no pipelining of bus transfers.
- The counter saturates and never wraps: exit at TIMEOUT-1 is mandatory.
- Stores: rdata and rdata_valid are unchanged. A store ends on bus_ready or timeout, exactly like a load.

Decomposition:
- Shared package (dm_pkg):
  - size codes SZ_NONE/SZ_WORD/SZ_HALF/SZ_BYTE = 0..3.
  - state encoding ST_IDLE/ST_REQ/ST_DONE (2 bits).
  - BE_ALL = 4'b1111.
- One natural sub-module: dm_align_chk, the combinational misalignment decode producing mis, exc_adel and exc_ades.
- FSM, counter and bus registers stay in dm_bridge.

Test Plan:
- lw, addr=0x0000_0010, bus_ready at the first REQ cycle with bus_rdata=0xDEADBEEF:
  - bus_addr=0x10, bus_be=1111, stall high for 2 cycles.
  - DONE cycle: rdata=0xDEADBEEF, rdata_valid pulses once.
- sb, addr=0x0000_0013, req_be=1000, wdata=0xAB000000, bus_ready after 3 wait cycles:
  - bus fields stable all 4 REQ cycles, bus_addr=0x10, bus_be=1000.
  - stall high 5 cycles total; no rdata_valid.
- lw addr=0x0000_0002 and sh addr=0x0000_0001:
  - exc_adel=1 and exc_ades=1 respectively in the same cycle.
  - bus_valid never rises; stall=0.
- No bus_ready, TIMEOUT=4:
  - bus_valid high exactly 4 cycles, then bus_fault pulses in DONE.
  - rdata=0, stall drops in the DONE cycle.
- rst_n driven low during the 2nd REQ cycle:
  - bus_valid and stall go to 0 asynchronously before the next clock edge; no bus_fault.
  - After release, a new lw completes normally.
- Back-to-back lw then sw, both with bus_ready=1:
  - two distinct transactions separated by the DONE and IDLE cycles.
  - the second uses the new address; the first's rdata holds through the store.
